cms_trace_collector: RTL

// - Parametrised trace collector for the continuous monitoring system: samples the CPU pc/instr stream, keeps retired-instruction events, and filters them through N address ranges plus start/end triggers.
// - Accepted events are buffered in an internal FIFO and streamed to the DMA over AXI-Stream.
// - Adds per-range include/exclude modes, a buffered output with overflow accounting, and a saturating timestamp delta.

---
 rtl/continuous_monitoring_system_pkg.sv | 41 ++++
 rtl/cms_trace_collector_range.sv | 71 +++++++
 rtl/edge_detector.sv | 22 ++
 rtl/cms_trace_collector.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types and constants for the continuous monitoring system.
// Control map, range bank layout and trace packet format.
package continuous_monitoring_system_pkg;

    localparam int XLEN            = 32;
    localparam int CTRL_ADDR_WIDTH = 8;
    localparam int CTRL_DATA_WIDTH = 32;
    localparam int CMS_RANGE_BASE  = 16;

    localparam logic [31:0] WFI_INSTR = 32'h1050_0073;

    typedef enum logic [CTRL_ADDR_WIDTH-1:0] {
        CMS_TRIG_START_EN   = 8'd0,
        CMS_TRIG_END_EN     = 8'd1,
        CMS_TRIG_START_ADDR = 8'd2,
        CMS_TRIG_END_ADDR   = 8'd3,
        CMS_WFI_STOPPED     = 8'd4,
        CMS_TS_CLEAR        = 8'd5,
        CMS_DROP_CLEAR      = 8'd6
    } cms_ctrl_addr_t;

    typedef enum logic [1:0] {
        CMS_RANGE_LO   = 2'd0,
        CMS_RANGE_HI   = 2'd1,
        CMS_RANGE_EN   = 2'd2,
        CMS_RANGE_MODE = 2'd3
    } cms_range_reg_t;

    // Timestamp delta is stored beside this in the FIFO (its width is a parameter).
    typedef struct packed {
        logic            last;
        logic            ovf;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } trace_pkt_t;

    function automatic int PKT_WIDTH(input int ts_width);
        return 1 + 32 + ts_width + XLEN;
    endfunction

endpackage

// File: rtl/cms_trace_collector_range.sv
// Address range register banks and include/exclude pass decision.
// Bank i lives at CMS_RANGE_BASE + 4*i: LO, HI, EN, MODE.
module cms_range_matcher
    import continuous_monitoring_system_pkg::*;
#(
    parameter int NO_OF_RANGES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [CTRL_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [CTRL_DATA_WIDTH-1:0] wr_data_i,
    input  logic [XLEN-1:0]            pc_i,
    output logic                       pass_o
);

    logic [XLEN-1:0]         lo_q [NO_OF_RANGES];
    logic [XLEN-1:0]         hi_q [NO_OF_RANGES];
    logic [NO_OF_RANGES-1:0] en_q;
    logic [NO_OF_RANGES-1:0] mode_q;

    logic [CTRL_ADDR_WIDTH-3:0] bank;
    logic [1:0]                 reg_sel;
    logic                       inc_en;
    logic                       inc_hit;
    logic                       exc_hit;

    assign bank    = wr_addr_i[CTRL_ADDR_WIDTH-1:2];
    assign reg_sel = wr_addr_i[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NO_OF_RANGES; i++) begin
                lo_q[i] <= '0;
                hi_q[i] <= '1;
            end
            en_q   <= '0;
            mode_q <= '0;
        end else if (wr_en_i) begin
            for (int i = 0; i < NO_OF_RANGES; i++) begin
                if (bank == (CTRL_ADDR_WIDTH-2)'(CMS_RANGE_BASE / 4 + i)) begin
                    case (reg_sel)
                        CMS_RANGE_LO:   lo_q[i]   <= wr_data_i[XLEN-1:0];
                        CMS_RANGE_HI:   hi_q[i]   <= wr_data_i[XLEN-1:0];
                        CMS_RANGE_EN:   en_q[i]   <= wr_data_i[0];
                        CMS_RANGE_MODE: mode_q[i] <= wr_data_i[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // An inverted range (lo > hi) can never satisfy both bounds.
    always_comb begin
        inc_en  = 1'b0;
        inc_hit = 1'b0;
        exc_hit = 1'b0;
        for (int i = 0; i < NO_OF_RANGES; i++) begin
            if (en_q[i]) begin
                if (!mode_q[i]) inc_en = 1'b1;
                if (pc_i >= lo_q[i] && pc_i <= hi_q[i]) begin
                    if (mode_q[i]) exc_hit = 1'b1;
                    else           inc_hit = 1'b1;
                end
            end
        end
        pass_o = (!inc_en || inc_hit) && !exc_hit;
    end

endmodule

// File: rtl/edge_detector.sv
// Rising-edge detector for a synchronous strobe.
// One-cycle pulse on the first cycle the input is seen high.
module edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/cms_trace_collector.sv
// Trace collector: pc/instr sampling, trigger and range filtering,
// packet FIFO with overflow accounting, AXI-Stream output.
module cms_trace_collector
    import continuous_monitoring_system_pkg::*;
#(
    parameter int NO_OF_RANGES    = 4,
    parameter int FIFO_DEPTH      = 16,
    parameter int TS_WIDTH        = 32,
    parameter int DROP_CNT_WIDTH  = 16,
    parameter int AXI_DATA_WIDTH  = 128,
    parameter bit CTRL_WE_POSEDGE = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [XLEN-1:0]               pc,
    input  logic [31:0]                   instr,
    input  logic [CTRL_ADDR_WIDTH-1:0]    ctrl_addr,
    input  logic [CTRL_DATA_WIDTH-1:0]    ctrl_wdata,
    input  logic                          ctrl_write_enable,
    input  logic [31:0]                   tlast_interval,
    output logic                          M_AXIS_tvalid,
    input  logic                          M_AXIS_tready,
    output logic [AXI_DATA_WIDTH-1:0]     M_AXIS_tdata,
    output logic                          M_AXIS_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_CNT_WIDTH-1:0]     drop_count,
    output logic                          wfi_stopped
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = PKT_WIDTH(TS_WIDTH);

    typedef logic [TS_WIDTH-1:0] ts_t;

    logic we_rise;
    logic wr_act;

    edge_detector u_we_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (ctrl_write_enable),
        .rise_o (we_rise)
    );

    assign wr_act = CTRL_WE_POSEDGE ? we_rise : ctrl_write_enable;

    logic wr_start_en, wr_end_en, wr_start_addr, wr_end_addr;
    logic wr_wfi, ts_clr, drop_clr;

    always_comb begin
        wr_start_en   = 1'b0;
        wr_end_en     = 1'b0;
        wr_start_addr = 1'b0;
        wr_end_addr   = 1'b0;
        wr_wfi        = 1'b0;
        ts_clr        = 1'b0;
        drop_clr      = 1'b0;
        if (wr_act) begin
            case (ctrl_addr)
                CMS_TRIG_START_EN:   wr_start_en   = 1'b1;
                CMS_TRIG_END_EN:     wr_end_en     = 1'b1;
                CMS_TRIG_START_ADDR: wr_start_addr = 1'b1;
                CMS_TRIG_END_ADDR:   wr_end_addr   = 1'b1;
                CMS_WFI_STOPPED:     wr_wfi        = 1'b1;
                CMS_TS_CLEAR:        ts_clr        = 1'b1;
                CMS_DROP_CLEAR:      drop_clr      = 1'b1;
                default: ;
            endcase
        end
    end

    // Stage 0: sample the cpu stream and flag a new retired pc.
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            ev_q;
    logic            ev_d;
    logic            wfi_q;

    assign ev_d = (pc != pc_q) && (pc != '0) && en && !wfi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= '0;
            ev_q    <= 1'b0;
        end else begin
            pc_q    <= pc;
            instr_q <= instr;
            ev_q    <= ev_d;
        end
    end

    // Stage 1: triggers and ranges.
    logic            start_en_q, end_en_q;
    logic [XLEN-1:0] start_addr_q, end_addr_q;
    logic            start_q, end_q, start_d, end_d;
    logic            start_hit, end_hit, gate;
    logic            range_pass;

    always_comb begin
        start_hit = ev_q && !wr_act && start_en_q && (pc_q == start_addr_q);
        end_hit   = ev_q && !wr_act && end_en_q && (pc_q == end_addr_q);
        start_d   = start_q;
        end_d     = end_q;
        if (end_hit) begin
            end_d   = 1'b1;
            start_d = 1'b0;
        end else if (start_hit) begin
            start_d = 1'b1;
            end_d   = 1'b0;
        end
        gate = (start_d || !start_en_q) && (!end_d || !end_en_q);
    end

    cms_range_matcher #(
        .NO_OF_RANGES (NO_OF_RANGES)
    ) u_ranges (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_act),
        .wr_addr_i (ctrl_addr),
        .wr_data_i (ctrl_wdata),
        .pc_i      (pc_q),
        .pass_o    (range_pass)
    );

    logic            s1_v_q;
    logic [XLEN-1:0] s1_pc_q;
    logic [31:0]     s1_instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s1_pc_q    <= '0;
            s1_instr_q <= '0;
        end else begin
            s1_v_q     <= ev_q && gate && range_pass;
            s1_pc_q    <= pc_q;
            s1_instr_q <= instr_q;
        end
    end

    // Enqueue side.
    logic [AW:0]               wr_ptr_q, rd_ptr_q, level;
    logic                      full, empty, pop, push_req, push, drop;
    ts_t                       ts_q, ts_d;
    logic [31:0]               beat_q, cnt_d;
    logic                      is_wfi, pkt_last, ovf_q;
    logic [DROP_CNT_WIDTH-1:0] drop_q;
    trace_pkt_t                new_pkt;

    assign level    = wr_ptr_q - rd_ptr_q;
    assign full     = (level == (AW+1)'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign pop      = !empty && M_AXIS_tready;
    assign push_req = s1_v_q && !wfi_q;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && !push;

    assign ts_d     = (ts_q == '1) ? ts_q : ts_q + ts_t'(1);
    assign cnt_d    = beat_q + 32'd1;
    assign is_wfi   = (s1_instr_q == WFI_INSTR);
    assign pkt_last = is_wfi || (tlast_interval != '0 && cnt_d == tlast_interval);

    always_comb begin
        new_pkt.last  = pkt_last;
        new_pkt.ovf   = ovf_q;
        new_pkt.instr = s1_instr_q;
        new_pkt.pc    = s1_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ts_q         <= '0;
            beat_q       <= '0;
            ovf_q        <= 1'b0;
            drop_q       <= '0;
            wfi_q        <= 1'b0;
            start_en_q   <= 1'b0;
            end_en_q     <= 1'b0;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            start_q      <= 1'b0;
            end_q        <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);

            if (ts_clr || push) ts_q <= '0;
            else                ts_q <= ts_d;

            if (tlast_interval == '0) beat_q <= '0;
            else if (push)            beat_q <= pkt_last ? '0 : cnt_d;

            if (drop)      ovf_q <= 1'b1;
            else if (push) ovf_q <= 1'b0;

            if (drop_clr)                 drop_q <= '0;
            else if (drop && drop_q != '1) drop_q <= drop_q + DROP_CNT_WIDTH'(1);

            if (wr_wfi)              wfi_q <= ctrl_wdata[0];
            else if (push && is_wfi) wfi_q <= 1'b1;

            if (wr_start_en)   start_en_q   <= ctrl_wdata[0];
            if (wr_end_en)     end_en_q     <= ctrl_wdata[0];
            if (wr_start_addr) start_addr_q <= ctrl_wdata[XLEN-1:0];
            if (wr_end_addr)   end_addr_q   <= ctrl_wdata[XLEN-1:0];
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    trace_pkt_t mem_pkt [FIFO_DEPTH];
    ts_t        mem_ts  [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pkt[wr_ptr_q[AW-1:0]] <= new_pkt;
            mem_ts[wr_ptr_q[AW-1:0]]  <= ts_d;
        end
    end

    trace_pkt_t head;
    ts_t        head_ts;

    assign head    = mem_pkt[rd_ptr_q[AW-1:0]];
    assign head_ts = mem_ts[rd_ptr_q[AW-1:0]];

    always_comb begin
        M_AXIS_tdata = '0;
        if (!empty) M_AXIS_tdata[PW-1:0] = {head.ovf, head.instr, head_ts, head.pc};
    end

    assign M_AXIS_tvalid = !empty;
    assign M_AXIS_tlast  = !empty && head.last;
    assign fifo_level    = level;
    assign drop_count    = drop_q;
    assign wfi_stopped   = wfi_q;

endmodule
